// File: rtl/match_reporter_if.sv
//------------------------------------------------------------------------------
// Module  : match_reporter_if
// Brief   : Valid/ready report port carrying {engine id, byte offset}.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface match_reporter_if #(
  parameter int ID_W  = 3,
  parameter int OFS_W = 16
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [ID_W-1:0]  rpt_id;
  logic [OFS_W-1:0] rpt_ofs;

  modport master (
    output rpt_valid,
    output rpt_id,
    output rpt_ofs,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_id,
    input  rpt_ofs,
    output rpt_ready
  );
endinterface

`default_nettype wire

// File: rtl/match_reporter.sv
//------------------------------------------------------------------------------
// Module  : match_reporter
// Brief   : Turns the first rise of each sticky engine match into one queued
//           {id, offset} report. Offset tracking built only with MATCH_RPT_OFS_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module match_reporter #(
  parameter int NUM_ENG    = 8,
  parameter int ID_W       = 3,
  parameter int OFS_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               en,
  input  wire logic               sod,
  input  wire logic [NUM_ENG-1:0] eng_out,
  match_reporter_if.master        rpt,
  output logic                    ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_ENG-1:0] prev_q, prev_d;
  logic [NUM_ENG-1:0] pend_q, pend_d;
  logic [NUM_ENG-1:0] new_hit;
  logic [NUM_ENG-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               fifo_empty, fifo_full;
  logic               push, pop;
  logic [ID_W-1:0]    id_mem_q [FIFO_DEPTH];
  logic [ID_W-1:0]    id_mem_d [FIFO_DEPTH];

`ifdef MATCH_RPT_OFS_EN
  logic [OFS_W-1:0]   ofs_cnt_q, ofs_cnt_d;
  logic [OFS_W-1:0]   ofs_hit_q [NUM_ENG];
  logic [OFS_W-1:0]   ofs_hit_d [NUM_ENG];
  logic [OFS_W-1:0]   ofs_mem_q [FIFO_DEPTH];
  logic [OFS_W-1:0]   ofs_mem_d [FIFO_DEPTH];
  logic [OFS_W-1:0]   grant_ofs;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = ~fifo_empty & rpt.rpt_ready;
  assign push       = grant_any & (~fifo_full | pop);
  assign new_hit    = en ? (eng_out & ~prev_q) : '0;
  // Isolate the lowest pending engine.
  assign grant_oh   = pend_q & (~pend_q + NUM_ENG'(1));

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
`ifdef MATCH_RPT_OFS_EN
    grant_ofs = '0;
`endif
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
`ifdef MATCH_RPT_OFS_EN
        grant_ofs = ofs_hit_q[i];
`endif
      end
    end
  end

  always_comb begin
    prev_d   = prev_q;
    ovf_d    = ovf_q | (|(new_hit & pend_q));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    id_mem_d = id_mem_q;
    if (en) begin
      prev_d = sod ? '0 : eng_out;
    end
    // A hit on an engine still pending keeps the older entry and is lost.
    pend_d = (pend_q & ~(push ? grant_oh : '0)) | (new_hit & ~pend_q);
    if (push) begin
      id_mem_d[wr_ptr_q] = grant_id;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef MATCH_RPT_OFS_EN
  always_comb begin
    ofs_cnt_d = ofs_cnt_q;
    ofs_hit_d = ofs_hit_q;
    ofs_mem_d = ofs_mem_q;
    if (en) begin
      if (sod) begin
        ofs_cnt_d = '0;
      end else if (ofs_cnt_q != '1) begin
        ofs_cnt_d = ofs_cnt_q + OFS_W'(1);
      end
    end
    for (int i = 0; i < NUM_ENG; i++) begin
      if (new_hit[i] && !pend_q[i]) begin
        ofs_hit_d[i] = ofs_cnt_q;
      end
    end
    if (push) begin
      ofs_mem_d[wr_ptr_q] = grant_ofs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ofs_cnt_q <= '0;
      for (int i = 0; i < NUM_ENG; i++) begin
        ofs_hit_q[i] <= '0;
      end
    end else begin
      ofs_cnt_q <= ofs_cnt_d;
      ofs_hit_q <= ofs_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    ofs_mem_q <= ofs_mem_d;
  end

  assign rpt.rpt_ofs = fifo_empty ? '0 : ofs_mem_q[rd_ptr_q];
`else
  assign rpt.rpt_ofs = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= '0;
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    id_mem_q <= id_mem_d;
  end

  assign rpt.rpt_valid = ~fifo_empty;
  assign rpt.rpt_id    = fifo_empty ? '0 : id_mem_q[rd_ptr_q];
  assign ovf           = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_match_reporter.sv
//------------------------------------------------------------------------------
// Module  : tb_match_reporter
// Brief   : Directed and random checks of match_reporter against a queue model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_match_reporter;

  localparam int NUM_ENG    = 8;
  localparam int ID_W       = 3;
  localparam int OFS_W      = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef MATCH_RPT_OFS_EN
  localparam bit OFS_ON = 1'b1;
`else
  localparam bit OFS_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en  = 1'b0;
  logic               sod = 1'b0;
  logic [NUM_ENG-1:0] eng_out = '0;
  logic               ovf;

  match_reporter_if #(.ID_W(ID_W), .OFS_W(OFS_W)) rpt ();

  match_reporter #(
    .NUM_ENG   (NUM_ENG),
    .ID_W      (ID_W),
    .OFS_W     (OFS_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sod    (sod),
    .eng_out(eng_out),
    .rpt    (rpt),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int ofs;
  } rpt_t;

  rpt_t mq[$];
  bit   mprev[NUM_ENG];
  bit   mpend[NUM_ENG];
  int   mhit[NUM_ENG];
  int   mcnt;
  bit   movf;
  int   got_id[$];
  int   got_ofs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int eofs(input int o);
    return OFS_ON ? o : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NUM_ENG; i++) begin
      mprev[i] = 1'b0;
      mpend[i] = 1'b0;
      mhit[i]  = 0;
    end
    mcnt = 0;
    movf = 1'b0;
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, rpt.rpt_valid}, {31'd0, mq.size() > 0});
    chk("id",    {29'd0, rpt.rpt_id},    (mq.size() > 0) ? mq[0].id : 0);
    chk("ofs",   {16'd0, rpt.rpt_ofs},   (mq.size() > 0) ? eofs(mq[0].ofs) : 0);
    chk("ovf",   {31'd0, ovf},           {31'd0, movf});
  endtask

  // One clock: drive, compare against the model, advance the model, tick.
  task automatic step(input bit e, input bit s, input logic [NUM_ENG-1:0] g, input bit r);
    bit   pop;
    int   gi;
    bit   oldpend[NUM_ENG];
    rpt_t ent;
    en = e; sod = s; eng_out = g; rpt.rpt_ready = r;
    #1;
    check_outputs();
    pop     = (mq.size() > 0) && r;
    oldpend = mpend;
    gi      = -1;
    for (int i = NUM_ENG - 1; i >= 0; i--) if (mpend[i]) gi = i;
    if (gi >= 0 && !(mq.size() < FIFO_DEPTH || pop)) gi = -1;
    if (pop) begin
      got_id.push_back(int'(rpt.rpt_id));
      got_ofs.push_back(int'(rpt.rpt_ofs));
      void'(mq.pop_front());
    end
    if (gi >= 0) begin
      ent.id  = gi;
      ent.ofs = mhit[gi];
      mq.push_back(ent);
      mpend[gi] = 1'b0;
    end
    if (e) begin
      for (int i = 0; i < NUM_ENG; i++) begin
        if (g[i] && !mprev[i]) begin
          if (oldpend[i]) movf = 1'b1;
          else begin
            mpend[i] = 1'b1;
            mhit[i]  = mcnt;
          end
        end
        mprev[i] = s ? 1'b0 : g[i];
      end
      mcnt = s ? 0 : ((mcnt == 65535) ? mcnt : mcnt + 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp3[6];
    int n2;
    int o2;
    logic [NUM_ENG-1:0] cur;
    bit rs, re, rr;
    exp3 = '{0, 2, 4, 5, 6, 7};
    rpt.rpt_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    // Single hit at offset 10
    step(1, 1, '0, 1);
    repeat (10) step(1, 0, '0, 1);
    got_id.delete(); got_ofs.delete();
    step(1, 0, 8'h08, 1);
    step(1, 0, 8'h08, 1);
    chk("t1_valid", {31'd0, rpt.rpt_valid}, 1);
    chk("t1_id",    {29'd0, rpt.rpt_id}, 3);
    chk("t1_ofs",   {16'd0, rpt.rpt_ofs}, eofs(10));
    repeat (5) step(1, 0, 8'h08, 1);
    chk("t1_count", got_id.size(), 1);

    // Simultaneous hits at offset 7
    step(1, 1, '0, 1);
    repeat (7) step(1, 0, '0, 1);
    step(1, 0, 8'h22, 1);
    step(1, 0, 8'h22, 1);
    chk("t2_id_a",  {29'd0, rpt.rpt_id}, 1);
    chk("t2_ofs_a", {16'd0, rpt.rpt_ofs}, eofs(7));
    step(1, 0, 8'h22, 1);
    chk("t2_id_b",  {29'd0, rpt.rpt_id}, 5);
    chk("t2_ofs_b", {16'd0, rpt.rpt_ofs}, eofs(7));
    step(1, 0, 8'h22, 1);

    // Backpressure
    step(1, 1, '0, 0);
    step(1, 0, 8'hF5, 0);
    repeat (6) step(1, 0, 8'hF5, 0);
    chk("t3_head_valid", {31'd0, rpt.rpt_valid}, 1);
    chk("t3_head_id",    {29'd0, rpt.rpt_id}, 0);
    got_id.delete(); got_ofs.delete();
    repeat (8) step(1, 0, 8'hF5, 1);
    chk("t3_count", got_id.size(), 6);
    for (int i = 0; i < 6 && i < got_id.size(); i++) chk("t3_order", got_id[i], exp3[i]);
    chk("t3_ovf", {31'd0, ovf}, 0);

    // Overflow: engine 2 stuck pending across a stream boundary
    step(1, 1, '0, 0);
    repeat (3) step(1, 0, '0, 0);
    step(1, 0, 8'h1B, 0);
    repeat (4) step(1, 0, 8'h1B, 0);
    step(1, 0, 8'h1F, 0);
    repeat (2) step(1, 0, 8'h1F, 0);
    step(1, 1, '0, 0);
    step(1, 0, '0, 0);
    step(1, 0, 8'h04, 0);
    step(1, 0, 8'h04, 0);
    chk("t4_ovf", {31'd0, ovf}, 1);
    got_id.delete(); got_ofs.delete();
    repeat (8) step(1, 0, 8'h04, 1);
    n2 = 0; o2 = -1;
    for (int i = 0; i < got_id.size(); i++) if (got_id[i] == 2) begin n2++; o2 = got_ofs[i]; end
    chk("t4_id2_count", n2, 1);
    chk("t4_id2_ofs", o2, eofs(8));

    // Async reset with three reports queued
    step(1, 1, '0, 0);
    step(1, 0, 8'h07, 0);
    repeat (5) step(1, 0, 8'h07, 0);
    chk("t5_pre_valid", {31'd0, rpt.rpt_valid}, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_valid", {31'd0, rpt.rpt_valid}, 0);
    chk("t5_async_ovf",   {31'd0, ovf}, 0);
    chk("t5_async_id",    {29'd0, rpt.rpt_id}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    repeat (5) step(1, 0, '0, 1);

    // Enable gating
    step(1, 1, '0, 1);
    repeat (4) step(1, 0, '0, 1);
    repeat (3) step(0, 0, 8'h01, 1);
    chk("t6_no_detect", {31'd0, rpt.rpt_valid}, 0);
    step(1, 0, 8'h01, 1);
    step(1, 0, 8'h01, 1);
    chk("t6_valid", {31'd0, rpt.rpt_valid}, 1);
    chk("t6_id",    {29'd0, rpt.rpt_id}, 0);
    chk("t6_ofs",   {16'd0, rpt.rpt_ofs}, eofs(4));
    step(1, 0, 8'h01, 1);

    // Random traffic
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      re = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 39) == 0);
      rr = ((n / 200) % 3 == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      if (re && rs) cur = '0;
      else if ($urandom_range(0, 5) == 0) cur = cur | (NUM_ENG'(1) << $urandom_range(0, NUM_ENG - 1));
      step(re, rs, cur, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
